// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, instruction
// field positions, FSM states and result-flag bit indices.
package alu_op_sequencer_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 4;
    localparam int REG_AW  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_LSL = 4'h5;
    localparam logic [OP_W-1:0] OP_LSR = 4'h6;
    localparam logic [OP_W-1:0] OP_ASR = 4'h7;
    localparam logic [OP_W-1:0] OP_SLT = 4'h8;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int RSV_MSB = 2;

    localparam int FLG_CARRY  = 0;
    localparam int FLG_BORROW = 1;
    localparam int FLG_OVF    = 2;
    localparam int FLG_ZERO   = 3;
    localparam int FLG_ERR    = 4;
    localparam int FLG_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_OUT
    } state_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_SLT;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// 8x16 register file: two async read ports, a writeback port and a load port.
// Writeback beats load on the same index. ALU_OP_SEQUENCER_R0_ZERO_EN pins r0 to 0.
module alu_seq_regfile
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [REG_AW-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);
`ifdef ALU_OP_SEQUENCER_R0_ZERO_EN
    localparam int FIRST_WR = 1;   // r0 only ever sees the reset value
`else
    localparam int FIRST_WR = 0;
`endif

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            for (int i = FIRST_WR; i < NREGS; i++) begin
                if (wb_en && wb_addr == REG_AW'(i))
                    regs[i] <= wb_data;
                else if (ld_en && ld_addr == REG_AW'(i))
                    regs[i] <= ld_data;
            end
        end
    end

    assign rd1_data = regs[rd1_addr];
    assign rd2_data = regs[rd2_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of the external 16-bit ALU: accept, read, execute, return.
// Optional build macro ALU_OP_SEQUENCER_R0_ZERO_EN (handled in the register file).
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               load_valid,
    input  logic [REG_AW-1:0]  load_addr,
    input  logic [DATA_W-1:0]  load_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_sel,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    input  logic               alu_borrow,
    input  logic               alu_overflow,
    input  logic               alu_zero,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic [FLG_W-1:0]   res_flags
);
    state_t             state, state_nxt;
    logic [REG_AW-1:0]  rd_q;
    logic [DATA_W-1:0]  rs1_data, rs2_data;
    logic               accept, wb_en;
    logic [FLG_W-1:0]   exec_flags;
    logic               unused_instr;

    assign accept       = instr_valid & instr_ready;
    assign wb_en        = (state == S_EXEC) && op_legal(alu_sel);
    assign unused_instr = ^instr[RSV_MSB:0];

    alu_seq_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rd1_addr (instr[RS1_MSB:RS1_LSB]),
        .rd1_data (rs1_data),
        .rd2_addr (instr[RS2_MSB:RS2_LSB]),
        .rd2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (alu_result),
        .ld_en    (load_valid),
        .ld_addr  (load_addr),
        .ld_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_OUT;
            S_OUT:   if (res_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == S_IDLE) && !rst;
        res_valid   = (state == S_OUT);
    end

    // The ALU drives every flag for every op; keep only the ones meaningful for the opcode.
    always_comb begin
        exec_flags = '0;
        if (op_legal(alu_sel)) begin
            exec_flags[FLG_CARRY]  = alu_carry  && (alu_sel == OP_ADD);
            exec_flags[FLG_BORROW] = alu_borrow && (alu_sel == OP_SUB);
            exec_flags[FLG_OVF]    = alu_overflow && (alu_sel == OP_ADD || alu_sel == OP_SUB);
            exec_flags[FLG_ZERO]   = alu_zero;
        end else begin
            exec_flags[FLG_ERR]  = 1'b1;
            exec_flags[FLG_ZERO] = 1'b1;
        end
    end

    // alu_sel doubles as the latched opcode for the rest of the operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_data  <= '0;
            res_flags <= '0;
        end else begin
            if (accept) begin
                rd_q    <= instr[RD_MSB:RD_LSB];
                alu_a   <= rs1_data;
                alu_b   <= rs2_data;
                alu_sel <= instr[OP_MSB:OP_LSB];
            end
            if (state == S_EXEC) begin
                res_data  <= op_legal(alu_sel) ? alu_result : '0;
                res_flags <= exec_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with a behavioural ALU and a
// register-array reference model; honours ALU_OP_SEQUENCER_R0_ZERO_EN.
module tb_alu_op_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        load_valid = 1'b0;
    logic [2:0]  load_addr = '0;
    logic [15:0] load_data = '0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    logic        alu_carry, alu_borrow, alu_overflow, alu_zero;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic [4:0]  res_flags;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_borrow(alu_borrow),
        .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags)
    );

    // Stand-in for the team ALU: it raises carry/borrow/overflow for every op,
    // so the sequencer's per-op masking is exercised.
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry    = alu_sum[16];
        alu_borrow   = alu_a < alu_b;
        alu_overflow = (alu_sel == 4'h1) ? (alu_a[15] != alu_b[15]) && ((alu_a - alu_b) >> 15 != 16'(alu_a[15]))
                                         : (alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15]);
        case (alu_sel)
            4'h0: alu_result = alu_sum[15:0];
            4'h1: alu_result = alu_a - alu_b;
            4'h2: alu_result = alu_a & alu_b;
            4'h3: alu_result = alu_a | alu_b;
            4'h4: alu_result = alu_a ^ alu_b;
            4'h5: alu_result = alu_a << alu_b[3:0];
            4'h6: alu_result = alu_a >> alu_b[3:0];
            4'h7: alu_result = 16'($signed(alu_a) >>> alu_b[3:0]);
            4'h8: alu_result = {15'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = alu_a ^ 16'hBAD0;
        endcase
        alu_zero = (alu_result == 16'h0);
    end

    // Reference model state
    logic [15:0] mregs [8];
    logic [15:0] exp_data;
    logic [4:0]  exp_flags;
    bit          exp_wr;
    logic [2:0]  cur_rd;
    int          last_wait;

    function automatic logic [15:0] rd_reg(input logic [2:0] i);
`ifdef ALU_OP_SEQUENCER_R0_ZERO_EN
        if (i == 3'd0) return 16'h0;
`endif
        return mregs[i];
    endfunction

    function automatic void wr_reg(input logic [2:0] i, input logic [15:0] v);
`ifdef ALU_OP_SEQUENCER_R0_ZERO_EN
        if (i == 3'd0) return;
`endif
        mregs[i] = v;
    endfunction

    // Expected result and {err,zero,ovf,borrow,carry} from integer arithmetic.
    function automatic void predict(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [4:0] f, output bit wr);
        int ua, ub, sa, sb, t;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        f = '0; wr = 1'b1; r = '0;
        case (op)
            4'h0: begin t = ua + ub; r = t[15:0]; f[0] = t > 65535;
                        f[2] = (sa + sb > 32767) || (sa + sb < -32768); end
            4'h1: begin t = ua - ub; r = t[15:0]; f[1] = ua < ub;
                        f[2] = (sa - sb > 32767) || (sa - sb < -32768); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: begin t = ua * (1 << b[3:0]); r = t[15:0]; end
            4'h6: begin t = ua / (1 << b[3:0]); r = t[15:0]; end
            4'h7: begin t = sa >>> b[3:0]; r = t[15:0]; end
            4'h8: r = (sa < sb) ? 16'd1 : 16'd0;
            default: begin r = '0; f = 5'b11000; wr = 1'b0; end
        endcase
        if (wr) f[3] = (r == 16'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        load_valid = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
        wr_reg(a, d);
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input bit ld_same = 0,
                         input logic [2:0] ld_a = 0, input logic [15:0] ld_d = 0);
        logic [15:0] a, b;
        int n;
        a = rd_reg(rs1); b = rd_reg(rs2);
        predict(op, a, b, exp_data, exp_flags, exp_wr);
        cur_rd = rd;
        instr = {op, rd, rs1, rs2, 3'($urandom)};
        instr_valid = 1'b1;
        if (ld_same) begin load_valid = 1'b1; load_addr = ld_a; load_data = ld_d; end
        n = 0;
        while (!instr_ready && n < 50) begin @(negedge clk); n++; end
        last_wait = n;
        if (!instr_ready) chk("accept_timeout", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0; load_valid = 1'b0;
        if (ld_same) wr_reg(ld_a, ld_d);
        chk("read_alu_a", 32'(alu_a), 32'(a));
        chk("read_alu_b", 32'(alu_b), 32'(b));
        chk("read_alu_sel", 32'(alu_sel), 32'(op));
        chk("read_res_valid", 32'(res_valid), 32'd0);
        chk("read_instr_ready", 32'(instr_ready), 32'd0);
    endtask

    task automatic collect(input int stall, input bit coll = 0, input logic [15:0] coll_d = 0,
                           input bit hold_next = 0);
        @(negedge clk);
        chk("exec_res_valid", 32'(res_valid), 32'd0);
        if (coll) begin load_valid = 1'b1; load_addr = cur_rd; load_data = coll_d; end
        @(negedge clk);
        load_valid = 1'b0;
        if (coll) wr_reg(cur_rd, coll_d);
        if (exp_wr) wr_reg(cur_rd, exp_data);
        chk("out_res_valid", 32'(res_valid), 32'd1);
        chk("out_res_data", 32'(res_data), 32'(exp_data));
        chk("out_res_flags", 32'(res_flags), 32'(exp_flags));
        if (hold_next) instr_valid = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_res_data", 32'(res_data), 32'(exp_data));
            chk("stall_res_flags", 32'(res_flags), 32'(exp_flags));
            chk("stall_instr_ready", 32'(instr_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_hs_res_valid", 32'(res_valid), 32'd0);
        chk("post_hs_instr_ready", 32'(instr_ready), 32'd1);
    endtask

    task automatic readback(input logic [2:0] r);
        issue(4'h3, r, r, r);
        collect(0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_flags", 32'(res_flags), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    endtask

    initial begin
        logic [3:0] op;
        for (int i = 0; i < 8; i++) mregs[i] = '0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_instr_ready", 32'(instr_ready), 32'd1);
        readback(3'd3);

        // ADD overflow, then SUB borrow
        load(3'd1, 16'h7FFF);
        load(3'd2, 16'h0001);
        issue(4'h0, 3'd3, 3'd1, 3'd2);
        collect(0);
        chk("add_ovf_data", 32'(exp_data), 32'h8000);
        readback(3'd3);
        issue(4'h1, 3'd4, 3'd2, 3'd1);
        collect(0);

        // Illegal opcode leaves rd untouched
        load(3'd5, 16'h1234);
        issue(4'hA, 3'd5, 3'd1, 3'd2);
        collect(0);
        readback(3'd5);

        // Backpressure with the next instruction already offered
        issue(4'h4, 3'd6, 3'd1, 3'd2);
        instr = {4'h2, 3'd7, 3'd3, 3'd4, 3'd0};
        collect(6, 0, 16'h0, 1);
        issue(4'h2, 3'd7, 3'd3, 3'd4);
        chk("b2b_accept_wait", 32'(last_wait), 32'd0);
        collect(0);

        // Load vs writeback collision, and load at acceptance
        issue(4'h0, 3'd2, 3'd1, 3'd1);
        collect(0, 1, 16'hAAAA);
        readback(3'd2);
        issue(4'h0, 3'd5, 3'd1, 3'd2, 1, 3'd1, 16'h0F0F);
        collect(0);
        readback(3'd1);
        issue(4'h1, 3'd1, 3'd1, 3'd2);
        collect(1);

        // r0 behaviour (hardwired under the R0 option, ordinary otherwise)
        load(3'd0, 16'hFFFF);
        issue(4'h0, 3'd1, 3'd0, 3'd0);
        collect(0);

        // Reset in the EXEC cycle aborts the writeback
        load(3'd6, 16'h5555);
        issue(4'h0, 3'd6, 3'd6, 3'd6);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        @(negedge clk);
        chk("rst_exec_instr_ready", 32'(instr_ready), 32'd1);
        readback(3'd6);
        readback(3'd1);

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                case ($urandom_range(0, 3))
                    0: load(3'($urandom), 16'h8000);
                    1: load(3'($urandom), 16'hFFFF);
                    default: load(3'($urandom), 16'($urandom));
                endcase
            end
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            issue(op, 3'($urandom), 3'($urandom), 3'($urandom),
                  $urandom_range(0, 5) == 0, 3'($urandom), 16'($urandom));
            collect($urandom_range(0, 2), $urandom_range(0, 5) == 0, 16'($urandom));
        end
        for (int r = 0; r < 8; r++) readback(3'(r));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
